// File: rtl/data_mem_pkg.sv
// Shared types and default geometry for the parametrised CPU data memory.
package data_mem_pkg;

   typedef enum logic {CLEAR, IDLE} state_t;

   localparam int DMEM_DATA_W = 8;
   localparam int DMEM_ADDR_W = 8;
   localparam int DMEM_DEPTH  = 256;

   // Index width for the storage array; a single-word memory still needs one bit.
   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with one write port and one registered, read-first read port.
module dmem_array #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Old contents are captured when a read and write hit the same word.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/data_memory_sp.sv
// Synchronous data memory: clear-after-reset FSM, range check and
// clear/user write-port arbitration around a block-RAM style array.
module data_memory_sp
   import data_mem_pkg::*;
#(
   parameter int DATA_W         = DMEM_DATA_W,
   parameter int ADDR_W         = DMEM_ADDR_W,
   parameter int DEPTH          = DMEM_DEPTH,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              wr,
   input  logic              rd,
   input  logic [ADDR_W-1:0] add,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              addr_err,
   output logic              busy
);

   localparam int IDX_W = idx_w(DEPTH);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

   state_t            state;
   logic [IDX_W-1:0]  cnt;
   logic              in_range;
   logic              clr_we;
   logic              user_we;
   logic              user_re;
   logic              arr_we;
   logic [IDX_W-1:0]  arr_waddr;
   logic [DATA_W-1:0] arr_wdata;
   logic [DATA_W-1:0] arr_rdata;
   logic              rd_zero;

   assign in_range = ({1'b0, add} < (ADDR_W + 1)'(DEPTH));

   assign clr_we  = rst_n && (state == CLEAR);
   assign user_we = rst_n && (state == IDLE) && wr && in_range;
   assign user_re = rst_n && (state == IDLE) && rd && in_range;

   assign arr_we    = clr_we || user_we;
   assign arr_waddr = clr_we ? cnt : add[IDX_W-1:0];
   assign arr_wdata = clr_we ? '0 : data_in;

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .waddr (arr_waddr),
      .wdata (arr_wdata),
      .re    (user_re),
      .raddr (add[IDX_W-1:0]),
      .rdata (arr_rdata)
   );

   // The array register is left unreset; rd_zero masks it after reset and
   // after an out-of-range read, so data_out is driven purely by flops.
   assign data_out = rd_zero ? '0 : arr_rdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         busy     <= (CLEAR_ON_RESET != 0);
         cnt      <= '0;
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
         rd_zero  <= 1'b1;
      end else begin
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
         case (state)
            CLEAR: begin
               if (cnt == LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            IDLE: begin
               busy <= 1'b0;
               if (rd) begin
                  rd_valid <= 1'b1;
                  rd_zero  <= !in_range;
               end
               addr_err <= (rd || wr) && !in_range;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_sp.sv
// Bench for data_memory_sp: a 16-word instance for the clear sequence and a
// 200-word instance driven with random traffic against an array model.
module tb_data_memory_sp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n_a, wr_a, rd_a;
   logic [7:0] add_a, din_a, dout_a;
   logic       rdv_a, aerr_a, busy_a;

   logic       rst_n_b, wr_b, rd_b;
   logic [7:0] add_b, din_b, dout_b;
   logic       rdv_b, aerr_b, busy_b;

   data_memory_sp #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .CLEAR_ON_RESET(1)) dut_a (
      .clk(clk), .rst_n(rst_n_a), .data_in(din_a), .wr(wr_a), .rd(rd_a), .add(add_a),
      .data_out(dout_a), .rd_valid(rdv_a), .addr_err(aerr_a), .busy(busy_a)
   );

   data_memory_sp #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .CLEAR_ON_RESET(1)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .data_in(din_b), .wr(wr_b), .rd(rd_b), .add(add_b),
      .data_out(dout_b), .rd_valid(rdv_b), .addr_err(aerr_b), .busy(busy_b)
   );

   int tests = 0;
   int fails = 0;

   logic [7:0] model [256];
   logic [7:0] last_b;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Counts negedge samples with busy high, starting at the current negedge.
   task automatic count_busy(input bit on_b, output int n);
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         if (!(on_b ? busy_b : busy_a)) break;
         n++;
         if (!on_b) begin
            check("a_clr_rd_valid", rdv_a, 1'b0);
            check("a_clr_addr_err", aerr_a, 1'b0);
         end
         @(negedge clk);
      end
   endtask

   task automatic step_a(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d,
                         input logic exp_v, input logic [7:0] exp_d);
      @(negedge clk);
      wr_a = w; rd_a = r; add_a = a; din_a = d;
      @(posedge clk);
      #1;
      check("a_rd_valid", rdv_a, exp_v);
      check("a_data_out", dout_a, exp_d);
      check("a_addr_err", aerr_a, 1'b0);
      wr_a = 1'b0; rd_a = 1'b0;
   endtask

   task automatic step_b(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
      logic in_r;
      @(negedge clk);
      wr_b = w; rd_b = r; add_b = a; din_b = d;
      @(posedge clk);
      #1;
      in_r = (a < 8'd200);
      if (r) last_b = in_r ? model[a] : 8'h00;
      check("b_rd_valid", rdv_b, r);
      check("b_addr_err", aerr_b, (w | r) & !in_r);
      check("b_data_out", dout_b, last_b);
      check("b_busy", busy_b, 1'b0);
      if (w && in_r) model[a] = d;
      wr_b = 1'b0; rd_b = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n_a = 1'b0; wr_a = 1'b0; rd_a = 1'b0; add_a = '0; din_a = '0;
      rst_n_b = 1'b0; wr_b = 1'b0; rd_b = 1'b0; add_b = '0; din_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("a_rst_data_out", dout_a, 8'h00);
      check("a_rst_rd_valid", rdv_a, 1'b0);
      check("a_rst_addr_err", aerr_a, 1'b0);
      check("a_rst_busy", busy_a, 1'b1);
      check("b_rst_data_out", dout_b, 8'h00);
      check("b_rst_busy", busy_b, 1'b1);

      // Clear with a write and read to address 3 held throughout.
      @(negedge clk);
      rst_n_a = 1'b1; rst_n_b = 1'b1;
      wr_a = 1'b1; rd_a = 1'b1; add_a = 8'd3; din_a = 8'hAA;
      count_busy(1'b0, n);
      wr_a = 1'b0; rd_a = 1'b0;
      check("a_busy_cycles", n, 16);

      for (int i = 0; i < 16; i++) step_a(1'b0, 1'b1, 8'(i), 8'h00, 1'b1, 8'h00);
      step_a(1'b1, 1'b0, 8'd5, 8'h3C, 1'b0, 8'h00);
      step_a(1'b0, 1'b1, 8'd5, 8'h00, 1'b1, 8'h3C);

      // Reset returns data_out to zero, then a reset mid-clear at count 7.
      @(negedge clk);
      rst_n_a = 1'b0;
      @(posedge clk);
      #1;
      check("a_rst2_data_out", dout_a, 8'h00);
      check("a_rst2_rd_valid", rdv_a, 1'b0);
      check("a_rst2_busy", busy_a, 1'b1);
      @(negedge clk);
      rst_n_a = 1'b1;
      repeat (7) @(negedge clk);
      check("a_busy_before_restart", busy_a, 1'b1);
      rst_n_a = 1'b0;
      @(negedge clk);
      rst_n_a = 1'b1;
      count_busy(1'b0, n);
      check("a_busy_after_restart", n, 16);
      step_a(1'b0, 1'b1, 8'd5, 8'h00, 1'b1, 8'h00);

      // Fresh clear of the 200-word instance, then directed and random traffic.
      @(negedge clk);
      rst_n_b = 1'b0;
      @(negedge clk);
      rst_n_b = 1'b1;
      count_busy(1'b1, n);
      check("b_busy_cycles", n, 200);
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
      last_b = 8'h00;

      step_b(1'b1, 1'b0, 8'h10, 8'h5C);
      step_b(1'b0, 1'b1, 8'h10, 8'h00);
      check("b_read_5c", dout_b, 8'h5C);
      step_b(1'b1, 1'b0, 8'h20, 8'h11);
      step_b(1'b1, 1'b1, 8'h20, 8'h22);
      check("b_read_first", dout_b, 8'h11);
      step_b(1'b0, 1'b1, 8'h20, 8'h00);
      check("b_read_new", dout_b, 8'h22);
      step_b(1'b1, 1'b0, 8'd250, 8'h77);
      step_b(1'b0, 1'b1, 8'd250, 8'h00);
      check("b_oor_read_zero", dout_b, 8'h00);
      step_b(1'b1, 1'b0, 8'd199, 8'hEE);
      step_b(1'b0, 1'b1, 8'd199, 8'h00);
      step_b(1'b0, 1'b1, 8'd200, 8'h00);
      step_b(1'b0, 1'b1, 8'd0, 8'h00);

      for (int i = 0; i < 400; i++)
         step_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), 8'($urandom));
      for (int i = 0; i < 200; i++) step_b(1'b0, 1'b1, 8'(i), 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/data_memory_sp.md
# data_memory_sp

Parametrised synchronous data memory, the successor to the CPU's 8-bit data memory. It adds configurable width and depth, a registered read with a valid strobe, out-of-range address detection, and an optional hardware clear sequence after reset. It sits on the datapath's load/store bus between the ALU/register file and the control unit. The control unit stalls on `busy`.

## Interface
- `DATA_W`, default 8: word width in bits.
- `ADDR_W`, default 8: address width in bits.
- `DEPTH`, default 256: number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W.
- `CLEAR_ON_RESET`, default 1: 1 = zero every word after reset; 0 = no clear, contents undefined.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `data_in` input DATA_W: write data.
- `wr` input 1: write request, sampled at the clock edge.
- `rd` input 1: read request, sampled at the clock edge.
- `add` input ADDR_W: word address for the read or write.
- `data_out` output DATA_W: registered read data; holds its value between reads.
- `rd_valid` output 1: one-cycle pulse; `data_out` is valid in that cycle.
- `addr_err` output 1: one-cycle pulse for an accepted `rd` or `wr` with `add` ≥ DEPTH.
- `busy` output 1: clear sequence in progress; all requests are ignored.

## Operation
- States:
  - CLEAR: a clear counter walks 0..DEPTH-1 and writes zeros.
  - IDLE: normal access.
- Reset, whenever `rst_n` is sampled low:
  - `data_out`=0, `rd_valid`=0, `addr_err`=0, clear counter=0.
  - If CLEAR_ON_RESET=1: state→CLEAR, `busy`=1.
  - Otherwise: state→IDLE, `busy`=0.
- CLEAR:
  - Each cycle with `rst_n` high writes mem[cnt]=0, then cnt+1.
  - When cnt=DEPTH-1, that word is written and state→IDLE.
  - `wr` and `rd` are ignored: no write, no `rd_valid`, no `addr_err`.
  - Reset mid-clear restarts the counter at 0.
- IDLE, write: `wr`=1 and `add`<DEPTH → mem[add]←`data_in` at the edge.
- IDLE, read: `rd`=1 and `add`<DEPTH → at the edge, `data_out`←mem[add] and `rd_valid`←1. Otherwise `rd_valid`←0.
- Same-cycle `rd` and `wr` to the same address: read-first. `data_out` returns the old word; the new word is visible to the next read.
- Same-cycle `rd` and `wr` to different addresses: both are performed.
- Out of range (`add`≥DEPTH), IDLE only:
  - A write is dropped and memory is unchanged.
  - A read loads `data_out`←0 and still pulses `rd_valid`.
  - In both cases `addr_err`←1 for one cycle.
- Address width: only the low ceil(log2 DEPTH) bits index the array, after the range check. No wrap-around aliasing.

## Timing
- Read latency 1 cycle: `rd` sampled at edge N → `data_out` and `rd_valid` valid after edge N, for cycle N+1.
- Back-to-back reads give one word per cycle. `rd_valid` stays high while `rd` is held.
- A write takes effect at the sampling edge. A read of the same address at edge N+1 returns the new data.
- Clear duration is exactly DEPTH cycles after the first edge with `rst_n` high. `busy` falls at edge DEPTH, so the first request is accepted at that edge.
- All outputs are registered. There are no combinational paths from inputs to outputs and no tri-state outputs.

## Structure
- Shared package `data_mem_pkg`:
  - state enum {CLEAR, IDLE}.
  - Default width/depth localparams for the 8-bit CPU.
- One sub-module, `dmem_array`:
  - DATA_W×DEPTH storage, one write port, one synchronous read port, read-first.
  - Keeps the array inferable as block RAM.
- Top level holds the FSM, clear counter, range check and write-port mux (clear vs user).

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=16 → `busy`=1 for exactly 16 cycles. Afterwards, reading addresses 0..15 returns 0x00 each with `rd_valid` pulses.
- During CLEAR, `wr` 0xAA to address 3 and `rd` of address 3 → no `rd_valid`. After `busy` falls, address 3 reads 0x00.
- IDLE: write 0x5C to address 0x10, then read 0x10 on the next cycle → `data_out`=0x5C one cycle after `rd`, `rd_valid`=1 for one cycle.
- Address 0x20 holds 0x11; simultaneous `wr` 0x22 and `rd` to 0x20 → `data_out`=0x11. The following read gives 0x22.
- DEPTH=200, ADDR_W=8: `wr` 0x77 to address 250 → `addr_err` pulses and memory is unchanged. `rd` of address 250 → `data_out`=0x00 with `rd_valid` and `addr_err` pulsing.
- `rst_n` low for one cycle at clear count 7 → counter restarts at 0. `busy` stays high a further DEPTH cycles after `rst_n` returns high.
